csa_accum_seq: RTL

- Sequential multi-operand adder controller built around a carry-save (3:2) reduction stage.
- Accepts a run of N unsigned operands over a valid/ready stream and folds each into redundant sum/carry registers, one operand per cycle, with no carry propagation.
- After the last operand, one cycle of ripple resolve produces the final binary sum.
- The result is held on a valid/ready output port.
- Sits between an operand source, such as a partial-product generator, and downstream arithmetic.

---
 rtl/csa_accum_seq.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/csa_accum_seq.sv
// ----------------------------------------------------------------------------
// csa_accum_seq
//   Sequential multi-operand adder. Operands arrive one per cycle over a
//   valid/ready stream and are folded into redundant sum/carry registers by a
//   3:2 carry-save stage, so no carry propagates while accumulating. After
//   the last operand a single ripple add resolves S+C into the final sum,
//   which is then held on a valid/ready result port.
//
// Ports:
//   CLK        clock, rising edge
//   RST_N      asynchronous active-low reset
//   START      begin a run (only looked at in IDLE)
//   NUM_OPS    operand count for the run, clamped to MAX_OPS
//   OP_VALID   operand present on OP_DATA
//   OP_DATA    unsigned operand, zero-extended to ACC_W
//   OP_READY   operand accepted when OP_VALID & OP_READY
//   RES_VALID  result available on RES_DATA
//   RES_DATA   final sum (ACC_W bits, cannot overflow for legal runs)
//   RES_READY  consumer takes the result
//   BUSY       high whenever not IDLE
// ----------------------------------------------------------------------------
module csa_accum_seq #(
    parameter int  WIDTH   = 32,
    parameter int  MAX_OPS = 16,
    localparam int CNT_W   = $clog2(MAX_OPS + 1),
    localparam int ACC_W   = WIDTH + $clog2(MAX_OPS)
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic [CNT_W-1:0] NUM_OPS,
    input  logic             OP_VALID,
    input  logic [WIDTH-1:0] OP_DATA,
    output logic             OP_READY,
    output logic             RES_VALID,
    output logic [ACC_W-1:0] RES_DATA,
    input  logic             RES_READY,
    output logic             BUSY
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_RESOLVE,
        ST_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [ACC_W-1:0] r_s;
    logic [ACC_W-1:0] r_c;
    logic [ACC_W-1:0] r_res;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_target;

    logic [ACC_W-1:0] w_x;
    logic [ACC_W-1:0] w_maj;
    logic [CNT_W-1:0] w_target_clamp;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_op_hs;

    assign w_target_clamp = (NUM_OPS > CNT_W'(MAX_OPS)) ? CNT_W'(MAX_OPS) : NUM_OPS;
    assign w_cnt_inc      = r_cnt + CNT_W'(1);
    // OP_READY is a pure decode of ACCUM, so the handshake needs only the state
    assign w_op_hs        = OP_VALID && (r_state == ST_ACCUM);

    // 3:2 compressor: sum bit is the XOR, carry is the majority moved up one bit
    assign w_x   = ACC_W'(OP_DATA);
    assign w_maj = (r_s & r_c) | (r_s & w_x) | (r_c & w_x);

    // State register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (START) begin
                    w_state_nxt = (w_target_clamp != '0) ? ST_ACCUM : ST_RESOLVE;
                end
            end
            ST_ACCUM: begin
                if (w_op_hs && (w_cnt_inc == r_target)) begin
                    w_state_nxt = ST_RESOLVE;
                end
            end
            ST_RESOLVE: begin
                w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                if (RES_READY) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output decode (state only, no input-to-output paths)
    always_comb begin
        OP_READY  = (r_state == ST_ACCUM);
        RES_VALID = (r_state == ST_DONE);
        BUSY      = (r_state != ST_IDLE);
    end

    assign RES_DATA = r_res;

    // Datapath: redundant accumulator, operand count and resolved result
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_s      <= '0;
            r_c      <= '0;
            r_cnt    <= '0;
            r_target <= '0;
            r_res    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (START) begin
                        r_target <= w_target_clamp;
                        r_s      <= '0;
                        r_c      <= '0;
                        r_cnt    <= '0;
                    end
                end
                ST_ACCUM: begin
                    if (w_op_hs) begin
                        r_s   <= r_s ^ r_c ^ w_x;
                        // MSB carry-out is dropped; it is zero for legal runs
                        r_c   <= w_maj << 1;
                        r_cnt <= w_cnt_inc;
                    end
                end
                ST_RESOLVE: begin
                    r_res <= r_s + r_c;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
